// File: rtl/demux_stream_nch_pkg.sv
// Shared definitions for the demux_stream_nch slice.
//   MODE_HOLD / MODE_CLEAR : output data behaviour once a channel empties
//   chanState_t            : per-channel EMPTY/FULL state encoding
//   selWidth()             : select width for a given channel count (min 1 bit)
package demux_stream_nch_pkg;

   localparam logic MODE_HOLD  = 1'b0;
   localparam logic MODE_CLEAR = 1'b1;

   typedef enum logic {
      CH_EMPTY = 1'b0,
      CH_FULL  = 1'b1
   } chanState_t;

   function automatic int selWidth(input int nCh);
      return (nCh > 1) ? $clog2(nCh) : 1;
   endfunction

endpackage

// File: rtl/demux_stream_nch_if.sv
// Producer/consumer bus of the demultiplexer.
//   in_valid / in_ready / sel / data_in : single producer side
//   out_data / out_valid / out_ready    : N_CH consumer channels, channel k at [k*DW +: DW]
// The master modport is the traffic source and sink (testbench / surrounding logic);
// the slave modport is the demultiplexer itself.
interface demux_stream_nch_if
   import demux_stream_nch_pkg::*;
#(
   parameter int DW   = 4,
   parameter int N_CH = 8
) ();

   localparam int SEL_W = selWidth(N_CH);

   logic                 in_valid;
   logic                 in_ready;
   logic [SEL_W-1:0]     sel;
   logic [DW-1:0]        data_in;
   logic [N_CH*DW-1:0]   out_data;
   logic [N_CH-1:0]      out_valid;
   logic [N_CH-1:0]      out_ready;

   modport master (
      output in_valid, sel, data_in, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_valid, sel, data_in, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/demux_stream_nch_chan_slot.sv
// One output channel of the demultiplexer: an EMPTY/FULL state bit plus a DW-wide
// holding register.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : accepted word is routed to this channel this cycle
//   take       : consumer takes the held word this cycle
//   mode       : MODE_HOLD keeps the last word, MODE_CLEAR zeroes it while empty
//   d          : incoming word
//   q          : held word
//   valid      : channel holds an unconsumed word
module demux_chan_slot
   import demux_stream_nch_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          take,
   input  logic          mode,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q,
   output logic          valid
);

   chanState_t    r_state;
   chanState_t    w_stateNext;
   logic [DW-1:0] r_data;

   // State register: a channel always comes out of reset empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CH_EMPTY;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next state: a load always leaves the channel full, even when the old word is
   // taken on the same edge; only a take without a load empties it.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         CH_EMPTY: if (load)          w_stateNext = CH_FULL;
         CH_FULL:  if (take && !load) w_stateNext = CH_EMPTY;
         default:                     w_stateNext = CH_EMPTY;
      endcase
   end

   // Data register: new words always win. In CLEAR mode the word is zeroed on any
   // edge that leaves the channel empty, which covers both the consuming edge and
   // an idle channel seeing a HOLD->CLEAR switch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (load) begin
         r_data <= d;
      end else if (mode == MODE_CLEAR && w_stateNext == CH_EMPTY) begin
         r_data <= '0;
      end
   end

   assign q     = r_data;
   assign valid = (r_state == CH_FULL);

endmodule

// File: rtl/demux_stream_nch.sv
// Registered 1-to-N_CH demultiplexer with valid/ready flow control.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : global enable; low blocks new input while channels still drain
//   mode       : MODE_HOLD / MODE_CLEAR output data behaviour
//   bus        : producer handshake, select, data and N_CH consumer channels
//   sel_err    : one-cycle pulse when a word with an out-of-range select is accepted
//   err_cnt    : saturating count of such accepts
module demux_stream_nch
   import demux_stream_nch_pkg::*;
#(
   parameter int DW     = 4,
   parameter int N_CH   = 8,
   parameter int ECNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   demux_stream_nch_if.slave  bus,
   output logic               sel_err,
   output logic [ECNT_W-1:0]  err_cnt
);

   logic [N_CH-1:0]   w_selOneHot;
   logic [N_CH-1:0]   w_load;
   logic              w_selInRange;
   logic              w_blocked;
   logic              w_accept;
   logic              r_selErr;
   logic [ECNT_W-1:0] r_errCnt;

   // Select decode. An out-of-range select decodes to no channel at all, so it can
   // never be blocked by a full channel and never loads one.
   always_comb begin
      w_selOneHot  = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_selOneHot[k] = (int'(bus.sel) == k);
      end
      w_selInRange = (int'(bus.sel) < N_CH);
   end

   // Ready depends only on the selected channel's occupancy: a full channel still
   // accepts when its consumer takes the old word on the same edge.
   always_comb begin
      w_blocked    = |(w_selOneHot & bus.out_valid & ~bus.out_ready);
      bus.in_ready = en & ~w_blocked;
      w_accept     = bus.in_valid & bus.in_ready;
      w_load       = w_selOneHot & {N_CH{w_accept}};
   end

   // One holding slot per channel; only the selected one ever sees a load.
   for (genvar g = 0; g < N_CH; g++) begin : gSlot
      demux_chan_slot #(
         .DW(DW)
      ) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (w_load[g]),
         .take  (bus.out_ready[g]),
         .mode  (mode),
         .d     (bus.data_in),
         .q     (bus.out_data[g*DW +: DW]),
         .valid (bus.out_valid[g])
      );
   end

   // Out-of-range accepts: the word is dropped, a single-cycle flag is raised and
   // the counter climbs until it sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_selErr <= 1'b0;
         r_errCnt <= '0;
      end else begin
         r_selErr <= w_accept & ~w_selInRange;
         if (w_accept && !w_selInRange && r_errCnt != {ECNT_W{1'b1}}) begin
            r_errCnt <= r_errCnt + ECNT_W'(1);
         end
      end
   end

   assign sel_err = r_selErr;
   assign err_cnt = r_errCnt;

endmodule
